// File: rtl/rgb_gray_mul_sched.sv
// rgb_gray_mul_sched: shares one pipelined 16x7 multiplier across the
// R/G/B grayscale products of a pixel and accumulates one gray sample.
// Ports: clk, reset (async, active-high); coef_r/g/b weights;
// s_valid/s_ready/s_r/s_g/s_b pixel input; mul_ce/mul_a/mul_b/mul_p
// multiplier side; m_valid/m_ready/m_gray registered gray output.
module rgb_gray_mul_sched #(
    parameter int DATA_W  = 16,
    parameter int COEF_W  = 7,
    parameter int MUL_LAT = 3,
    parameter int SHIFT   = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COEF_W-1:0]        coef_r,
    input  logic [COEF_W-1:0]        coef_g,
    input  logic [COEF_W-1:0]        coef_b,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_r,
    input  logic [DATA_W-1:0]        s_g,
    input  logic [DATA_W-1:0]        s_b,
    output logic                     mul_ce,
    output logic [DATA_W-1:0]        mul_a,
    output logic [COEF_W-1:0]        mul_b,
    input  logic [DATA_W+COEF_W-1:0] mul_p,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_gray
);

    localparam int ACC_W = DATA_W + COEF_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RED   = 2'd1;
    localparam logic [1:0] S_GREEN = 2'd2;
    localparam logic [1:0] S_BLUE  = 2'd3;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [DATA_W-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic [COEF_W-1:0]       cr_q, cr_d, cg_q, cg_d, cb_q, cb_d;
    // Each tag entry is {valid, chan[1:0]}; the top entry lines up with mul_p.
    logic [MUL_LAT-1:0][2:0] tag_q, tag_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_W-1:0]       m_gray_q, m_gray_d;
    logic                    accept;
    logic [2:0]              tag_in;
    logic [2:0]              tail;

    assign mul_ce  = !(m_valid_q && !m_ready);
    assign s_ready = mul_ce && (state_q == S_IDLE || state_q == S_BLUE);
    assign accept  = s_valid && s_ready;
    assign tail    = tag_q[MUL_LAT-1];
    assign m_valid = m_valid_q;
    assign m_gray  = m_gray_q;

    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        tag_in = 3'b000;
        unique case (state_q)
            S_RED: begin
                mul_a  = r_q;
                mul_b  = cr_q;
                tag_in = {1'b1, CH_R};
            end
            S_GREEN: begin
                mul_a  = g_q;
                mul_b  = cg_q;
                tag_in = {1'b1, CH_G};
            end
            S_BLUE: begin
                mul_a  = b_q;
                mul_b  = cb_q;
                tag_in = {1'b1, CH_B};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        cr_d      = cr_q;
        cg_d      = cg_q;
        cb_d      = cb_q;
        tag_d     = tag_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        m_gray_d  = m_gray_q;
        if (m_ready) m_valid_d = 1'b0;
        if (mul_ce) begin
            unique case (state_q)
                S_IDLE:  state_d = accept ? S_RED : S_IDLE;
                S_RED:   state_d = S_GREEN;
                S_GREEN: state_d = S_BLUE;
                S_BLUE:  state_d = accept ? S_RED : S_IDLE;
                default: state_d = S_IDLE;
            endcase
            // Capturing in BLUE is safe: the old b_q is sampled by the
            // multiplier on this same edge.
            if (accept) begin
                r_d  = s_r;
                g_d  = s_g;
                b_d  = s_b;
                cr_d = coef_r;
                cg_d = coef_g;
                cb_d = coef_b;
            end
            tag_d = {tag_q[MUL_LAT-2:0], tag_in};
            if (tail[2]) begin
                case (tail[1:0])
                    CH_R: acc_d = ACC_W'(mul_p);
                    CH_G: acc_d = acc_q + ACC_W'(mul_p);
                    CH_B: begin
                        m_gray_d  = DATA_W'((acc_q + ACC_W'(mul_p)) >> SHIFT);
                        m_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            cr_q      <= '0;
            cg_q      <= '0;
            cb_q      <= '0;
            tag_q     <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_gray_q  <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            cr_q      <= cr_d;
            cg_q      <= cg_d;
            cb_q      <= cb_d;
            tag_q     <= tag_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_gray_q  <= m_gray_d;
        end
    end

endmodule

// File: tb/tb_rgb_gray_mul_sched.sv
// tb_rgb_gray_mul_sched: directed and random pixels through the scheduler
// with a 3-stage multiplier model and a queue-based gray reference.
module tb_rgb_gray_mul_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  coef_r = 7'd38, coef_g = 7'd75, coef_b = 7'd15;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_r = '0, s_g = '0, s_b = '0;
    logic        mul_ce;
    logic [15:0] mul_a;
    logic [6:0]  mul_b;
    logic [22:0] mul_p;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_gray;

    logic [22:0] p1 = '0, p2 = '0, p3 = '0;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    int acc_edge = 0;
    int out_cnt = 0;
    int prev_out = 0;
    int n_out = 0;
    bit acc_seen, out_seen, last_s_ready;
    bit chk_space = 0, have_prev = 0;
    logic [15:0] last_gray = '0;
    logic [15:0] exp_q[$];

    rgb_gray_mul_sched dut (
        .clk(clk), .reset(reset),
        .coef_r(coef_r), .coef_g(coef_g), .coef_b(coef_b),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .m_valid(m_valid), .m_ready(m_ready), .m_gray(m_gray)
    );

    always #5 clk = ~clk;

    // Multiplier: three clock-enabled register stages, no reset.
    always @(posedge clk) begin
        if (mul_ce) begin
            p1 <= mul_a * mul_b;
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign mul_p = p3;

    function automatic logic [15:0] ref_gray(input longint r, input longint g,
                                              input longint b, input longint cr,
                                              input longint cg, input longint cb);
        longint s;
        s = r * cr + g * cg + b * cb;
        return 16'(s >> 7);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        last_s_ready = s_ready;
        acc_seen = s_valid && s_ready;
        out_seen = m_valid;
        if (acc_seen) begin
            exp_q.push_back(ref_gray(s_r, s_g, s_b, coef_r, coef_g, coef_b));
            acc_edge = cnt + 1;
        end
        if (m_valid) out_cnt = cnt;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("gray", m_gray, e);
            end
            if (chk_space && have_prev) check("spacing", cnt - prev_out, 3);
            prev_out = cnt;
            have_prev = 1;
            last_gray = m_gray;
            n_out++;
        end
        @(posedge clk);
        cnt++;
        #1;
    endtask

    task automatic send(input logic [15:0] r, input logic [15:0] g,
                        input logic [15:0] b);
        bit ok;
        ok = 0;
        s_r = r;
        s_g = g;
        s_b = b;
        s_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (acc_seen) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 80 && exp_q.size() > 0; k++) tick();
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        bit seen;
        logic [15:0] held;

        // Reset state
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_gray", m_gray, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_mul_ce", mul_ce, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 1);

        // 255 grey with default weights and latency
        send(16'd255, 16'd255, 16'd255);
        s_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_seen) begin
                seen = 1;
                break;
            end
        end
        check("lat_seen", seen, 1);
        check("latency", out_cnt - acc_edge, 6);
        check("gray255", last_gray, 255);
        drain();

        // Red only, then full scale
        send(16'd100, 16'd0, 16'd0);
        s_valid = 1'b0;
        drain();
        check("gray100", last_gray, 29);
        send(16'hFFFF, 16'hFFFF, 16'hFFFF);
        s_valid = 1'b0;
        drain();
        check("gray_full", last_gray, 16'hFFFF);

        // Back-to-back random pixels
        chk_space = 1;
        have_prev = 0;
        n0 = n_out;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_r = 16'($urandom_range(0, 65535));
            s_g = 16'($urandom_range(0, 65535));
            s_b = 16'($urandom_range(0, 65535));
            coef_r = 7'($urandom_range(0, 60));
            coef_g = 7'($urandom_range(0, 60));
            coef_b = 7'($urandom_range(0, 8));
            for (int j = 0; j < 3; j++) begin
                tick();
                check("s_ready_pat", last_s_ready, (j == 0));
                if (i == 7 && j == 0) s_valid = 1'b0;
            end
        end
        drain();
        check("b2b_count", n_out - n0, 8);
        chk_space = 0;

        // Stall with one pending sample and two pixels in flight
        coef_r = 7'd38;
        coef_g = 7'd75;
        coef_b = 7'd15;
        m_ready = 1'b0;
        n0 = n_out;
        send(16'd1200, 16'd3400, 16'd5600);
        send(16'd40000, 16'd20000, 16'd10000);
        send(16'd7, 16'd65000, 16'd300);
        s_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (m_valid) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("stall_pending", seen, 1);
        held = m_gray;
        check("stall_first", held, ref_gray(1200, 3400, 5600, 38, 75, 15));
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_ce", mul_ce, 0);
            check("stall_valid", m_valid, 1);
            check("stall_gray", m_gray, held);
        end
        m_ready = 1'b1;
        drain();
        check("stall_count", n_out - n0, 3);
        check("stall_last", last_gray, ref_gray(7, 65000, 300, 38, 75, 15));

        // Reset mid-pixel during GREEN
        send(16'd9000, 16'd9000, 16'd9000);
        s_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_gray", m_gray, 0);
        check("mid_rst_mul_a", mul_a, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_ready", s_ready, 1);
        n0 = n_out;
        send(16'd1000, 16'd2000, 16'd3000);
        s_valid = 1'b0;
        drain();
        for (int k = 0; k < 8; k++) tick();
        check("post_rst_count", n_out - n0, 1);
        check("post_rst_gray", last_gray, 1820);

        // Coefficients change right after accept
        send(16'd500, 16'd600, 16'd700);
        s_valid = 1'b0;
        coef_r = 7'd127;
        coef_g = 7'd127;
        coef_b = 7'd127;
        drain();
        check("coef_sample", last_gray, 582);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_gray_mul_sched.md
# rgb_gray_mul_sched

Issue scheduler that time-shares one pipelined unsigned multiplier (16-bit × 7-bit → 23-bit, 3 clock-enabled register stages) across the R, G and B products of the grayscale conversion. It accepts one pixel per handshake and issues its three coefficient products on consecutive cycles. It tracks in-flight products with a tag pipeline, accumulates the weighted sum and emits one registered gray sample per pixel. It sits between the pixel stream input and the gray output stage of the rgb-to-gray datapath, and it owns the multiplier's `ce`.

## Interface
- DATA_W, 16: width of each colour component and of the gray result.
- COEF_W, 7: coefficient width; must equal the multiplier's b-port width.
- MUL_LAT, 3: number of ce-enabled edges from operands applied to product visible on `mul_p`.
- SHIFT, 7: right shift applied to the weighted sum.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- coef_r, coef_g, coef_b  in  COEF_W each  weights, sampled at pixel accept (defaults in system: 38/75/15).
- s_valid  in  1  pixel valid.
- s_ready  out  1  pixel accept.
- s_r, s_g, s_b  in  DATA_W each  colour components.
- mul_ce  out  1  multiplier clock enable.
- mul_a  out  DATA_W  multiplier operand a.
- mul_b  out  COEF_W  multiplier operand b.
- mul_p  in  DATA_W+COEF_W  multiplier product.
- m_valid  out  1  gray sample valid (registered).
- m_ready  in  1  downstream accept.
- m_gray  out  DATA_W  gray sample (registered).

## Operation
- Stall rule: `mul_ce = !(m_valid && !m_ready)`. While `mul_ce` = 0, the FSM, tag pipeline, accumulator and holding registers all freeze.
- FSM states: IDLE, RED, GREEN, BLUE.
  - `s_ready` = `mul_ce && (state == IDLE || state == BLUE)`.
  - IDLE: on accept, capture r/g/b and the coefficients, then go to RED.
  - RED → GREEN → BLUE, one step per ce cycle.
  - BLUE: on accept, capture the next pixel and go to RED; otherwise go to IDLE.
- Issue: in RED, GREEN and BLUE, `mul_a`/`mul_b` are driven combinationally from the holding registers with the matching channel and coefficient. In IDLE both are 0.
- Tag pipeline: MUL_LAT entries of {valid, chan[1:0]}, shifted on every ce edge.
  - The entry inserted is {1, chan} in RED/GREEN/BLUE and {0, x} in IDLE.
  - The tail entry is aligned with `mul_p`.
- Accumulator: DATA_W+COEF_W+2 bits, updated from the tail entry on each ce edge.
  - Valid R tail: acc = mul_p.
  - Valid G tail: acc = acc + mul_p.
  - Valid B tail: load `m_gray` = (acc + mul_p) >> SHIFT, truncated to DATA_W bits, and set `m_valid`.
- Output register: `m_valid` clears on `m_ready` unless a B result loads on the same edge. Because a B load requires `mul_ce`, a load never overwrites an undrained sample.
- Width rule: the sum is computed without overflow. With coefficient sum ≤ 2^SHIFT, the result fits DATA_W bits. The block does not saturate; a larger coefficient sum truncates (integration error, not checked).
- Reset (asynchronous, any time including mid-pixel):
  - state = IDLE, tags cleared, acc = 0.
  - `m_valid` = 0, `m_gray` = 0.
  - `mul_ce` = 1, `mul_a` = 0, `mul_b` = 0.
  - In-flight products are discarded. `s_ready` reads 1 once reset deasserts.

## Timing
- Throughput: one pixel per 3 cycles sustained, with no bubble between back-to-back pixels.
- Latency: for an accept at edge E0 with no stall, R/G/B operands are sampled at E1/E2/E3. `m_valid` rises after edge E(MUL_LAT+3), which is E6 at the default.
- Stall: cycles with `m_ready` low while `m_valid` is high add 1:1 to latency. No product, tag or pixel is lost or duplicated.
- `s_ready` is combinational from state and `m_valid`/`m_ready`. No input-to-output combinational path exists other than `m_ready` → `mul_ce` → `s_ready`.

## Test plan
- R=G=B=255, coefficients 38/75/15, `m_ready`=1 → `m_gray` = 255, with `m_valid` high exactly 6 edges after accept.
- R=100, G=0, B=0 → `m_gray` = 29 (3800 >> 7). Then R=G=B=65535 → `m_gray` = 65535, with no accumulator overflow.
- 8 back-to-back pixels, `s_valid` held high → `s_ready` pattern 1,0,0 repeating; outputs arrive in order at one per 3 cycles, each matching the reference model.
- `m_ready` low for 10 cycles while a sample is pending and two pixels are in flight → `mul_ce` low, `m_gray` stable. After release, all three results arrive in order and correct.
- `reset` pulsed during GREEN of a pixel → immediately `m_valid`=0, `m_gray`=0, `mul_a`=0. The next pixel after reset produces only its own correct result, with no stale partial sum.
- Coefficients changed on the cycle after accept → the result uses the coefficients sampled at accept.
